bsg_manycore_store_fence: RTL and testbench

Outstanding remote-store tracker and fence unit for a manycore tile. It sits on the tile's outbound side, between the core's remote-store issue path and the return network. It counts remote stores accepted by the network and retires them as return (acknowledge) packets arrive. It throttles issue when the counter saturates and completes a core fence request only once every outstanding store has been acknowledged.

---
 rtl/bsg_manycore_pkg.sv | 25 ++
 rtl/bsg_counter_up_down.sv | 44 ++++
 rtl/bsg_manycore_store_fence.sv | 104 ++++++++++
 tb/tb_bsg_manycore_store_fence.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore types: return-packet layout and store-fence FSM states.
package bsg_manycore_pkg;

  // Width of the zero pad above the coordinates in a return packet.
  localparam int unsigned ret_pad_width_gp = 5;

  // Reference coordinate widths for the shared packet typedef.
  localparam int unsigned x_cord_width_gp = 4;
  localparam int unsigned y_cord_width_gp = 4;

  // Return packet: {pad, y_cord, x_cord}, x in the LSBs.
  typedef struct packed {
    logic [ret_pad_width_gp-1:0] pad;
    logic [y_cord_width_gp-1:0]  y_cord;
    logic [x_cord_width_gp-1:0]  x_cord;
  } bsg_manycore_ret_packet_s;

  // Fence FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } fence_state_e;

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down counter that saturates at max_val_p and holds at zero on a
// stray decrement, flagging it on underflow_o for that cycle.
module bsg_counter_up_down #(
  parameter int unsigned max_val_p = 64,
  localparam int unsigned width_lp = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o,
  output logic                underflow_o
);

  localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] one_lp = width_lp'(1);

  logic [width_lp-1:0] count_r, count_n;

  // Next count: simultaneous up and down cancel out.
  always_comb begin
    count_n     = count_r;
    underflow_o = 1'b0;
    case ({up_i, down_i})
      2'b10: begin
        if (count_r != max_lp) count_n = count_r + one_lp;
      end
      2'b01: begin
        if (count_r == '0) underflow_o = 1'b1;
        else               count_n     = count_r - one_lp;
      end
      default: count_n = count_r;
    endcase
  end

  // Count register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_r <= '0;
    else         count_r <= count_n;
  end

  assign count_o = count_r;

endmodule

// File: rtl/bsg_manycore_store_fence.sv
// Outstanding remote-store tracker and fence unit. Counts stores accepted by
// the network, retires them on matching return packets, throttles issue at
// saturation or while draining, and completes a fence once all are acked.
module bsg_manycore_store_fence
  import bsg_manycore_pkg::*;
#(
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned max_out_p      = 64,
  localparam int unsigned ret_packet_width_lp = ret_pad_width_gp + x_cord_width_p
                                                + y_cord_width_p,
  localparam int unsigned cntr_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [x_cord_width_p-1:0]      my_x_i,
  input  logic [y_cord_width_p-1:0]      my_y_i,
  input  logic                           store_v_i,
  input  logic                           store_ready_i,
  output logic                           issue_ready_o,
  input  logic                           ret_v_i,
  input  logic [ret_packet_width_lp-1:0] ret_data_i,
  output logic                           ret_ready_o,
  input  logic                           fence_v_i,
  output logic                           fence_done_o,
  output logic [cntr_width_lp-1:0]       count_o,
  output logic                           err_underflow_o,
  output logic                           err_misroute_o
);

  localparam logic [cntr_width_lp-1:0] max_count_lp = cntr_width_lp'(max_out_p);

  // Same layout as bsg_manycore_ret_packet_s, sized to this tile's coordinates.
  typedef struct packed {
    logic [ret_pad_width_gp-1:0] pad;
    logic [y_cord_width_p-1:0]   y_cord;
    logic [x_cord_width_p-1:0]   x_cord;
  } ret_packet_s;

  ret_packet_s  ret_pkt;
  fence_state_e state_r, state_n;
  logic         issue, ack, misroute, underflow;
  logic         err_underflow_r, err_misroute_r;

  assign ret_pkt     = ret_packet_s'(ret_data_i);
  assign ret_ready_o = 1'b1;

  // Issue readiness depends on registered state only, never on store_v_i.
  assign issue_ready_o = (count_o != max_count_lp) && (state_r == StIdle);
  assign issue         = store_v_i & store_ready_i & issue_ready_o;

  assign ack = ret_v_i
             & (ret_pkt.x_cord == my_x_i)
             & (ret_pkt.y_cord == my_y_i)
             & (ret_pkt.pad == '0);
  assign misroute = ret_v_i & ~ack;

  bsg_counter_up_down #(
    .max_val_p (max_out_p)
  ) u_counter (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .up_i        (issue),
    .down_i      (ack),
    .count_o     (count_o),
    .underflow_o (underflow)
  );

  // Fence FSM next state and done pulse.
  always_comb begin
    state_n      = state_r;
    fence_done_o = 1'b0;
    unique case (state_r)
      StIdle:  if (fence_v_i) state_n = StDrain;
      StDrain: if (count_o == '0) state_n = StDone;
      StDone: begin
        fence_done_o = 1'b1;
        state_n      = StIdle;
      end
      default: state_n = StIdle;
    endcase
  end

  // Fence FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= StIdle;
    else         state_r <= state_n;
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_underflow_r <= 1'b0;
      err_misroute_r  <= 1'b0;
    end else begin
      if (underflow) err_underflow_r <= 1'b1;
      if (misroute)  err_misroute_r  <= 1'b1;
    end
  end

  assign err_underflow_o = err_underflow_r;
  assign err_misroute_o  = err_misroute_r;

endmodule

// File: tb/tb_bsg_manycore_store_fence.sv
// Directed bench for bsg_manycore_store_fence. A second instance with a
// small max_out_p shares the stimulus to exercise issue saturation.
module tb_bsg_manycore_store_fence;

  localparam int unsigned XW = 4;
  localparam int unsigned YW = 3;
  localparam int unsigned RW = 5 + XW + YW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [XW-1:0] my_x = 4'd5;
  logic [YW-1:0] my_y = 3'd3;
  logic          store_v, store_ready, ret_v, fence_v;
  logic [RW-1:0] ret_data;

  logic       issue_ready, ret_ready, fence_done, err_uf, err_mr;
  logic [3:0] count;
  logic       s_issue_ready, s_ret_ready, s_fence_done, s_err_uf, s_err_mr;
  logic [2:0] s_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bsg_manycore_store_fence #(
    .x_cord_width_p (XW),
    .y_cord_width_p (YW),
    .max_out_p      (8)
  ) u_dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .my_x_i          (my_x),
    .my_y_i          (my_y),
    .store_v_i       (store_v),
    .store_ready_i   (store_ready),
    .issue_ready_o   (issue_ready),
    .ret_v_i         (ret_v),
    .ret_data_i      (ret_data),
    .ret_ready_o     (ret_ready),
    .fence_v_i       (fence_v),
    .fence_done_o    (fence_done),
    .count_o         (count),
    .err_underflow_o (err_uf),
    .err_misroute_o  (err_mr)
  );

  bsg_manycore_store_fence #(
    .x_cord_width_p (XW),
    .y_cord_width_p (YW),
    .max_out_p      (4)
  ) u_sat (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .my_x_i          (my_x),
    .my_y_i          (my_y),
    .store_v_i       (store_v),
    .store_ready_i   (store_ready),
    .issue_ready_o   (s_issue_ready),
    .ret_v_i         (ret_v),
    .ret_data_i      (ret_data),
    .ret_ready_o     (s_ret_ready),
    .fence_v_i       (fence_v),
    .fence_done_o    (s_fence_done),
    .count_o         (s_count),
    .err_underflow_o (s_err_uf),
    .err_misroute_o  (s_err_mr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i     = 1'b1;
    store_v     = 1'b0;
    store_ready = 1'b1;
    ret_v       = 1'b0;
    fence_v     = 1'b0;
    ret_data    = {5'b0, my_y, my_x};
    repeat (2) step();

    // Reset values.
    check("rst_count", 32'(count), 0);
    check("rst_issue_ready", 32'(issue_ready), 1);
    check("rst_ret_ready", 32'(ret_ready), 1);
    check("rst_fence_done", 32'(fence_done), 0);
    check("rst_err_uf", 32'(err_uf), 0);
    check("rst_err_mr", 32'(err_mr), 0);
    reset_i = 1'b0;
    step();

    // Three issues then three matching acks.
    store_v = 1'b1;
    step(); check("iss1", 32'(count), 1);
    step(); check("iss2", 32'(count), 2);
    step(); check("iss3", 32'(count), 3);
    store_v = 1'b0;
    ret_v   = 1'b1;
    step(); check("ack1", 32'(count), 2);
    step(); check("ack2", 32'(count), 1);
    step(); check("ack3", 32'(count), 0);
    ret_v = 1'b0;
    check("ack_err_uf", 32'(err_uf), 0);
    check("ack_err_mr", 32'(err_mr), 0);

    // Five stores: small instance saturates at 4, main reaches 5.
    store_v = 1'b1;
    repeat (4) step();
    check("sat_count4", 32'(s_count), 4);
    check("sat_ready0", 32'(s_issue_ready), 0);
    check("main_ready_at4", 32'(issue_ready), 1);
    step();
    check("sat_5th_dropped", 32'(s_count), 4);
    check("main_count5", 32'(count), 5);
    // Same-cycle issue and ack: main holds at 5, saturated one only retires.
    ret_v = 1'b1;
    step();
    check("both_hold5", 32'(count), 5);
    check("sat_ack_count", 32'(s_count), 3);
    check("sat_ready_back", 32'(s_issue_ready), 1);
    store_v = 1'b0;
    ret_v   = 1'b0;
    do_reset();

    // Fence with two outstanding stores, acks in cycles 3 and 6.
    store_v = 1'b1;
    repeat (2) step();
    store_v = 1'b0;
    check("fence_pre_count", 32'(count), 2);
    for (int k = 0; k <= 9; k++) begin
      check($sformatf("fence_done_c%0d", k), 32'(fence_done), (k == 8) ? 1 : 0);
      check($sformatf("fence_ready_c%0d", k), 32'(issue_ready),
            (k == 0 || k == 9) ? 1 : 0);
      check($sformatf("fence_count_c%0d", k), 32'(count),
            (k <= 3) ? 2 : (k <= 6) ? 1 : 0);
      ret_v   = (k == 3 || k == 6);
      store_v = (k >= 1 && k <= 8); // must be blocked while draining
      fence_v = (k <= 8);
      step();
    end
    ret_v   = 1'b0;
    store_v = 1'b0;
    check("fence_post_count", 32'(count), 0);

    // Ack with count zero -> underflow.
    ret_v = 1'b1;
    step();
    ret_v = 1'b0;
    check("uf_count", 32'(count), 0);
    check("uf_flag", 32'(err_uf), 1);
    check("uf_no_mr", 32'(err_mr), 0);

    // Misrouted packet (x+1) with one store outstanding.
    store_v = 1'b1;
    step();
    store_v  = 1'b0;
    ret_data = {5'b0, my_y, my_x + 4'd1};
    ret_v    = 1'b1;
    step();
    ret_v    = 1'b0;
    ret_data = {5'b0, my_y, my_x};
    check("mr_count", 32'(count), 1);
    check("mr_flag", 32'(err_mr), 1);
    check("uf_sticky", 32'(err_uf), 1);
    step();
    check("mr_sticky", 32'(err_mr), 1);
    do_reset();
    check("err_cleared", 32'({err_uf, err_mr}), 0);

    // Asynchronous reset while draining with three outstanding.
    store_v = 1'b1;
    repeat (3) step();
    store_v = 1'b0;
    fence_v = 1'b1;
    repeat (2) step();
    check("drain_count3", 32'(count), 3);
    check("drain_ready0", 32'(issue_ready), 0);
    #3;
    reset_i = 1'b1;
    #1;
    check("async_count", 32'(count), 0);
    check("async_idle_ready", 32'(issue_ready), 1);
    check("async_done", 32'(fence_done), 0);
    fence_v = 1'b0;
    step();
    reset_i = 1'b0;
    step();
    check("post_async_count", 32'(count), 0);
    check("post_async_done", 32'(fence_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
